// File: rtl/regfile_write_tracer.sv
// rtl/regfile_write_tracer.sv - timestamped trace FIFO for regfile writes; optional TRACE_FILTER_R0_EN
module regfile_write_tracer #(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [31:0]              data_writeReg,
    input  logic                     trace_enable,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CYCLE_W-1:0]       rd_cycle,
    output logic [4:0]               rd_reg,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CYCLE_W-1:0] cyc_q, cyc_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        dropped_q, dropped_d;

    logic [CYCLE_W-1:0] cyc_mem  [DEPTH];
    logic [4:0]         reg_mem  [DEPTH];
    logic [31:0]        data_mem [DEPTH];

    logic qual;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

`ifdef TRACE_FILTER_R0_EN
    assign qual = trace_enable && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
`else
    assign qual = trace_enable && ctrl_writeEnable;
`endif

    assign full    = (count_q == CW'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop     = rd_valid && rd_ready;
    // a pop on the same edge frees the head slot, so a full FIFO can still accept
    assign push_ok = qual && (!full || pop);
    assign drop    = qual && full && !pop;

    // next-state for counter, pointers, occupancy and drop bookkeeping
    always_comb begin
        cyc_d      = cyc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (trace_enable) begin
            cyc_d = cyc_q + CYCLE_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // control state register, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // entry storage; stamped with the pre-increment cycle value, no reset needed
    always_ff @(posedge clock) begin
        if (push_ok && !reset) begin
            cyc_mem[wr_ptr_q]  <= cyc_q;
            reg_mem[wr_ptr_q]  <= ctrl_writeReg;
            data_mem[wr_ptr_q] <= data_writeReg;
        end
    end

    // head entry is masked to zero when empty so uncleared storage never leaks out
    assign rd_cycle = rd_valid ? cyc_mem[rd_ptr_q]  : '0;
    assign rd_reg   = rd_valid ? reg_mem[rd_ptr_q]  : '0;
    assign rd_data  = rd_valid ? data_mem[rd_ptr_q] : '0;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_regfile_write_tracer.sv
// tb/tb_regfile_write_tracer.sv - scoreboard bench for regfile_write_tracer
module tb_regfile_write_tracer;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic        trace_enable = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_cycle;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] dropped;

    regfile_write_tracer #(.DEPTH(DEPTH), .CYCLE_W(16)) dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .trace_enable(trace_enable),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_cycle(rd_cycle),
        .rd_reg(rd_reg), .rd_data(rd_data), .count(count),
        .overflow(overflow), .dropped(dropped)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] c;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] m_cyc  = '0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_drop = '0;
    int          checks = 0;
    int          errors = 0;

    // drive one cycle of stimulus, update the model, compare pops and post-edge state
    task automatic step(input logic we, input logic [4:0] r, input logic [31:0] d,
                        input logic en, input logic rdy);
        bit   full, pop, q;
        ent_t e;
        ctrl_writeEnable = we;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        trace_enable     = en;
        rd_ready         = rdy;
        #1;
        checks++;
        if (rd_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL rd_valid got %0b want %0b", rd_valid, sb.size() != 0);
        end
        full = (sb.size() == DEPTH);
        pop  = rdy && (sb.size() != 0);
        if (pop) begin
            e = sb.pop_front();
            checks++;
            if (rd_cycle !== e.c || rd_reg !== e.r || rd_data !== e.d) begin
                errors++;
                $display("FAIL pop_entry got c=%0d r=%0d d=%h want c=%0d r=%0d d=%h",
                         rd_cycle, rd_reg, rd_data, e.c, e.r, e.d);
            end
        end
`ifdef TRACE_FILTER_R0_EN
        q = en && we && (r != 5'd0);
`else
        q = en && we;
`endif
        if (q) begin
            if (!full || pop) begin
                e.c = m_cyc; e.r = r; e.d = d;
                sb.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop++;
            end
        end
        if (en) m_cyc++;
        @(posedge clock);
        #1;
        checks++;
        if (count !== 5'(sb.size()) || overflow !== m_ovf || dropped !== m_drop) begin
            errors++;
            $display("FAIL state got cnt=%0d ovf=%0b drp=%0d want cnt=%0d ovf=%0b drp=%0d",
                     count, overflow, dropped, sb.size(), m_ovf, m_drop);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || dropped !== 16'd0 ||
            rd_data !== 32'd0 || rd_cycle !== 16'd0 || rd_reg !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got v=%0b cnt=%0d ovf=%0b drp=%0d d=%h",
                     rd_valid, count, overflow, dropped, rd_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0);
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL disabled_count got %0d want 0", count);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'd42, 1'b1, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_cycle !== 16'd5 || rd_reg !== 5'd3 || rd_data !== 32'd42) begin
            errors++;
            $display("FAIL single_write got v=%0b c=%0d r=%0d d=%0d want v=1 c=5 r=3 d=42",
                     rd_valid, rd_cycle, rd_reg, rd_data);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop rd_valid got %0b want 0", rd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] prev;
        for (int i = 1; i <= 19; i++) step(1'b1, 5'(i), 32'(100 + i), 1'b1, 1'b0);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || dropped !== 16'd3) begin
            errors++;
            $display("FAIL overflow got cnt=%0d ovf=%0b drp=%0d want cnt=16 ovf=1 drp=3",
                     count, overflow, dropped);
        end
        prev = '0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_reg !== 5'(i + 1) || (i > 0 && rd_cycle <= prev)) begin
                errors++;
                $display("FAIL drain_order got r=%0d c=%0d want r=%0d c>%0d",
                         rd_reg, rd_cycle, i + 1, prev);
            end
            prev = rd_cycle;
            step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) step(1'b1, 5'(i + 8), $urandom, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b1);
        checks++;
        if (count !== 5'd16 || dropped !== 16'd3) begin
            errors++;
            $display("FAIL full_push_pop got cnt=%0d drp=%0d want cnt=16 drp=3", count, dropped);
        end
        for (int i = 0; i < 15; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        checks++;
        if (rd_reg !== 5'd7 || rd_data !== 32'hDEADBEEF || count !== 5'd1) begin
            errors++;
            $display("FAIL last_entry got r=%0d d=%h cnt=%0d want r=7 d=deadbeef cnt=1",
                     rd_reg, rd_data, count);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic test_r0();
        step(1'b1, 5'd0, 32'd9, 1'b1, 1'b0);
`ifdef TRACE_FILTER_R0_EN
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL r0_filtered count got %0d want 0", count);
        end
`else
        checks++;
        if (count !== 5'd1 || rd_reg !== 5'd0 || rd_data !== 32'd9) begin
            errors++;
            $display("FAIL r0_captured got cnt=%0d r=%0d d=%0d want cnt=1 r=0 d=9",
                     count, rd_reg, rd_data);
        end
`endif
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 20), 32'(i), 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || dropped !== 16'd0 ||
            rd_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d v=%0b ovf=%0b drp=%0d d=%h",
                     count, rd_valid, overflow, dropped, rd_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        m_cyc = '0; m_ovf = 1'b0; m_drop = '0;
        step(1'b1, 5'd12, 32'h1234, 1'b1, 1'b0);
        checks++;
        if (rd_cycle !== 16'd0 || rd_reg !== 5'd12) begin
            errors++;
            $display("FAIL post_reset_stamp got c=%0d r=%0d want c=0 r=12", rd_cycle, rd_reg);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_r0();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_tracer.md
# regfile_write_tracer

Hardware trace buffer for the register-file write port. It sits directly downstream of the processor's writeback port, tapping the same `ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg` signals that drive the regfile. It timestamps each qualifying write with an enabled-cycle count and buffers it in a FIFO. A consumer (debug UART, on-chip checker or bench) drains the FIFO with a valid/ready handshake, so the write trace survives after simulation-only `$fdisplay` logging is gone.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `CYCLE_W`, 16: width of the cycle timestamp.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `ctrl_writeEnable`  in  1: regfile write enable from the processor.
- `ctrl_writeReg`  in  5: regfile destination register.
- `data_writeReg`  in  32: regfile write data.
- `trace_enable`  in  1: capture and cycle counting are active while high.
- `rd_ready`  in  1: consumer accepts the head entry.
- `rd_valid`  out  1: head entry is present.
- `rd_cycle`  out  CYCLE_W: timestamp of the head entry.
- `rd_reg`  out  5: register number of the head entry.
- `rd_data`  out  32: write data of the head entry.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `overflow`  out  1: sticky; set when any qualifying write is dropped.
- `dropped`  out  16: saturating count of dropped writes.

## Operation
- Cycle counter `cyc`:
  - Reset value 0.
  - Increments by 1 on every rising edge where `trace_enable` is 1; holds otherwise.
  - Wraps modulo 2^CYCLE_W.
- Qualifying write, evaluated on a rising edge: `trace_enable && ctrl_writeEnable`, plus the r0 filter (see Configuration).
- Push:
  - Stores {`cyc` pre-increment value, `ctrl_writeReg`, `data_writeReg`} at the tail.
  - The first enabled edge after reset is therefore stamped 0.
- Pop: occurs on a rising edge with `rd_valid && rd_ready`. The head pointer advances.
- Show-ahead FIFO:
  - `rd_cycle`, `rd_reg` and `rd_data` reflect the head entry combinationally from storage.
  - `rd_valid` = (`count` != 0).
  - When `rd_valid` is 0, the `rd_*` data outputs are don't-care.
- Boundary conditions:
  - Full and push, no pop: the write is dropped. `overflow` is set to 1. `dropped` increments, saturating at 65535. Stored entries are unchanged.
  - Full and push with pop on the same edge: the push is accepted, the head is removed and `count` stays at DEPTH. There is no drop.
  - Empty and push: the push is accepted and `count` becomes 1. A pop is impossible because `rd_valid` is 0.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- `overflow` and `dropped` clear only on `reset`.
- Reset values:
  - `rd_valid` = 0, `count` = 0, `overflow` = 0, `dropped` = 0.
  - `cyc` = 0; both pointers = 0.
  - `rd_*` data outputs are 0 from a cleared storage read. Storage itself is not required to be cleared; the `rd_*` data outputs must read 0 while `count` = 0 after reset.

## Timing
- Capture latency is 1 edge: a write qualified on edge N appears on `rd_*`, with `rd_valid` = 1, immediately after edge N if the FIFO was empty.
- The handshake completes on the edge where `rd_valid && rd_ready`. The next entry, or `rd_valid` = 0, is visible after that edge.
- `rd_ready` may be held high continuously, giving 1 pop per cycle.
- Throughput is 1 push and 1 pop per cycle.
- `count`, `overflow` and `dropped` update on the same edge as the causing event.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately, with no clock needed.
  - Any in-flight push or pop on a coincident edge is discarded.
  - Operation resumes on the first rising edge after `reset` deasserts.

## Configuration
- `TRACE_FILTER_R0_EN`:
  - Defined: writes with `ctrl_writeReg` = 0 are not qualifying. They are neither stored nor counted as dropped. This matches the convention that writes to r0 are invisible.
  - Undefined: writes to r0 qualify like any other register.
  - The cycle counter is unaffected in both cases.

## Test plan
- Reset → `rd_valid` = 0, `count` = 0, `overflow` = 0, `dropped` = 0. With `trace_enable` = 0 and 10 writes applied, `count` stays 0 and `cyc` stays 0.
- `trace_enable` = 1; a write of rd = 3, data = 42 on the 6th enabled edge → after that edge `rd_valid` = 1, `rd_cycle` = 5, `rd_reg` = 3, `rd_data` = 42. After one `rd_ready` pulse, `rd_valid` = 0.
- With `rd_ready` = 0, write rd = 1..19 with data = 100+i → `count` = 16, `overflow` = 1, `dropped` = 3. Draining yields rd = 1..16 in order, and the stamps are strictly increasing.
- FIFO full and `rd_ready` = 1, with a write of rd = 7, data = 0xDEADBEEF → `count` stays 16, `dropped` is unchanged, and that entry emerges last after 16 pops.
- Write rd = 0, data = 9 → with `TRACE_FILTER_R0_EN`, `count` is unchanged. Without the macro, an entry with `rd_reg` = 0, `rd_data` = 9 is captured.
- After 5 entries are pushed and `overflow` = 1, assert `reset` between edges → `count` = 0, `rd_valid` = 0, `overflow` = 0 before the next edge. The next write is stamped 0.
